// File: rtl/light_decoder_pkg.sv
// Shared colour codes, RGB constants and FSM state for light_decoder.
// Also provides the byte classifier used by rgb_decode.
package light_pkg;

  localparam logic [2:0] COL_BLACK   = 3'd0;
  localparam logic [2:0] COL_BLUE    = 3'd1;
  localparam logic [2:0] COL_GREEN   = 3'd2;
  localparam logic [2:0] COL_CYAN    = 3'd3;
  localparam logic [2:0] COL_RED     = 3'd4;
  localparam logic [2:0] COL_MAGENTA = 3'd5;
  localparam logic [2:0] COL_YELLOW  = 3'd6;
  localparam logic [2:0] COL_WHITE   = 3'd7;

  localparam logic [23:0] RGB_BLACK   = 24'h000000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  function automatic logic byte_ok(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/light_decoder_rgb_decode.sv
// Combinational RGB classifier: value -> 3-bit colour code plus ok flag.
// Ports: value[23:0] in; colour[2:0], ok out (colour meaningful only if ok).
module rgb_decode
  import light_pkg::*;
(
  input  logic [23:0] value,
  output logic [2:0]  colour,
  output logic        ok
);

  assign ok = byte_ok(value[23:16])
            & byte_ok(value[15:8])
            & byte_ok(value[7:0]);

  // A legal byte is all-zeros or all-ones, so its MSB is the colour bit.
  assign colour = {value[23], value[15], value[7]};

endmodule

// File: rtl/light_decoder.sv
// Debounces/qualifies the RGB light bus and reports the committed colour.
// Ports: clk, rst, light[23:0] in; colour, valid, err, changed, change_count out.
module light_decoder
  import light_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] light,
  output logic [2:0]  colour,
  output logic        valid,
  output logic        err,
  output logic        changed,
  output logic [7:0]  change_count
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  state_t      state_q, state_d;
  logic [23:0] light_q;
  logic [23:0] cand_q, cand_d;
  logic [23:0] held_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        commit;
  logic [2:0]  dec_colour;
  logic        dec_ok;

  rgb_decode u_dec (
    .value  (cand_q),
    .colour (dec_colour),
    .ok     (dec_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_SETTLE;
        cand_d  = light_q;
        cnt_d   = 8'd1;
      end
      ST_SETTLE: begin
        if (light_q != cand_q) begin
          cand_d = light_q;
          cnt_d  = 8'd1;
        end else if (cnt_q == STABLE) begin
          commit  = 1'b1;
          state_d = ST_LOCKED;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_LOCKED: begin
        if (light_q != held_q) begin
          state_d = ST_SETTLE;
          cand_d  = light_q;
          cnt_d   = 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // colour doubles as the last decodable code, so an err commit
  // followed by the old colour produces no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      light_q      <= '0;
      held_q       <= '0;
      colour       <= COL_BLACK;
      valid        <= 1'b0;
      err          <= 1'b0;
      changed      <= 1'b0;
      change_count <= '0;
    end else begin
      light_q <= light;
      changed <= 1'b0;
      if (commit) begin
        held_q <= cand_q;
        if (dec_ok) begin
          colour <= dec_colour;
          valid  <= 1'b1;
          err    <= 1'b0;
          if (dec_colour != colour) begin
            changed <= 1'b1;
            if (change_count != 8'hFF)
              change_count <= change_count + 8'd1;
          end
        end else begin
          valid <= 1'b0;
          err   <= 1'b1;
        end
      end
    end
  end

endmodule
